mips_mc_control: RTL

//  Main control FSM for the multicycle MIPS datapath. Sits directly downstream of the instruction register:
//  - consumes the latched opcode (IR[31:26]);
//  - produces every datapath enable, including IRwrite, which loads that register.

---
 rtl/mips_mc_control.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control
// Purpose  : Main control FSM for the multicycle MIPS datapath. Sequences
//            fetch / decode / execute / memory / writeback, stalling on the
//            memory-ready handshake, and drives every datapath enable.
// Config   : MIPS_MC_ILLEGAL_TRAP_EN - when defined, an unknown opcode
//            parks the FSM in TRAP (illegal_op=1) until reset; otherwise
//            it is treated as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  assign state = cur_state;

  // State register; asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; opcode is only looked at in DECODE and MEMADR.
  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:   nxt_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) begin
          nxt_state = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          nxt_state = S_EXEC;
        end else if (opcode == OP_BEQ) begin
          nxt_state = S_BRANCH;
        end else if (opcode == OP_J) begin
          nxt_state = S_JUMP;
        end else if (opcode == OP_ADDI) begin
          nxt_state = S_ADDIEX;
        end else begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
          nxt_state = S_TRAP;
`else
          nxt_state = S_FETCH;
`endif
        end
      end
      S_MEMADR: begin
        // Only LW/SW reach here; anything else drops back to fetch safely.
        if (opcode == OP_LW) begin
          nxt_state = S_MEMRD;
        end else if (opcode == OP_SW) begin
          nxt_state = S_MEMWR;
        end else begin
          nxt_state = S_FETCH;
        end
      end
      S_MEMRD:   nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   nxt_state = S_FETCH;
      S_MEMWR:   nxt_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    nxt_state = S_RTYPEWB;
      S_RTYPEWB: nxt_state = S_FETCH;
      S_BRANCH:  nxt_state = S_FETCH;
      S_JUMP:    nxt_state = S_FETCH;
      S_ADDIEX:  nxt_state = S_ADDIWB;
      S_ADDIWB:  nxt_state = S_FETCH;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      S_TRAP:    nxt_state = S_TRAP;
`else
      S_TRAP:    nxt_state = S_FETCH;
`endif
      // Encodings 13-15 are unused; recover to fetch.
      default:   nxt_state = S_FETCH;
    endcase
  end

  // Moore output decode; only the FETCH register loads follow mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  assign illegal_op = (cur_state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule
`default_nettype wire
